// File: rtl/scic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scic_pkg
// Description : Shared definitions for the SCIC control unit: opcode values,
//               sequencer state encodings, accumulator source and ALU
//               operation encodings, plus small opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package scic_pkg;

    localparam int OPCODE_W = 4;

    // Sequencer states; the encoding is visible on the state_dbg output.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcodes (IR[7:4]); 4'hA..4'hE are unassigned and fault the machine.
    localparam logic [OPCODE_W-1:0] c_OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] c_OP_LDA  = 4'h1;
    localparam logic [OPCODE_W-1:0] c_OP_STA  = 4'h2;
    localparam logic [OPCODE_W-1:0] c_OP_ADD  = 4'h3;
    localparam logic [OPCODE_W-1:0] c_OP_SUB  = 4'h4;
    localparam logic [OPCODE_W-1:0] c_OP_AND  = 4'h5;
    localparam logic [OPCODE_W-1:0] c_OP_JMP  = 4'h6;
    localparam logic [OPCODE_W-1:0] c_OP_JZ   = 4'h7;
    localparam logic [OPCODE_W-1:0] c_OP_IN   = 4'h8;
    localparam logic [OPCODE_W-1:0] c_OP_OUT  = 4'h9;
    localparam logic [OPCODE_W-1:0] c_OP_HALT = 4'hF;

    // Accumulator write-data source select.
    localparam logic [1:0] c_SRC_ALU = 2'd0;
    localparam logic [1:0] c_SRC_MEM = 2'd1;
    localparam logic [1:0] c_SRC_SW  = 2'd2;

    // ALU operation select.
    localparam logic [1:0] c_ALU_ADD  = 2'd0;
    localparam logic [1:0] c_ALU_SUB  = 2'd1;
    localparam logic [1:0] c_ALU_AND  = 2'd2;
    localparam logic [1:0] c_ALU_PASS = 2'd3;

    // Opcodes whose operand read in EXEC is written to the accumulator in WB.
    function automatic logic op_needs_wb(input logic [OPCODE_W-1:0] op);
        return (op == c_OP_LDA) || (op == c_OP_ADD) ||
               (op == c_OP_SUB) || (op == c_OP_AND);
    endfunction

    function automatic logic op_is_illegal(input logic [OPCODE_W-1:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scic_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : scic_ctrl_if
// Description : Bundle between the SCIC control unit and the datapath/top
//               level. Names are from the control unit's point of view
//               (i_ = into the control unit, o_ = out of it).
//   slave  : control-unit side (consumes run/step/opcode/acc_zero)
//   master : datapath/top side (drives run/step/opcode/acc_zero)
// Revision    : 1.0 - initial release
// ============================================================================
interface scic_ctrl_if
    import scic_pkg::*;
#(
    parameter int COUNT_W = 16
) ();
    logic                i_run;
    logic                i_step;
    logic [OPCODE_W-1:0] i_opcode;
    logic                i_acc_zero;
    logic                o_addr_sel;
    logic                o_mem_rd;
    logic                o_mem_wr;
    logic                o_ir_load;
    logic                o_pc_inc;
    logic                o_pc_load;
    logic                o_acc_load;
    logic [1:0]          o_acc_src;
    logic [1:0]          o_alu_op;
    logic                o_led_load;
    logic                o_halted;
    logic                o_fault;
    logic [2:0]          o_state_dbg;
    logic [COUNT_W-1:0]  o_instr_count;

    modport slave (
        input  i_run, i_step, i_opcode, i_acc_zero,
        output o_addr_sel, o_mem_rd, o_mem_wr, o_ir_load, o_pc_inc, o_pc_load,
               o_acc_load, o_acc_src, o_alu_op, o_led_load, o_halted, o_fault,
               o_state_dbg, o_instr_count
    );

    modport master (
        output i_run, i_step, i_opcode, i_acc_zero,
        input  o_addr_sel, o_mem_rd, o_mem_wr, o_ir_load, o_pc_inc, o_pc_load,
               o_acc_load, o_acc_src, o_alu_op, o_led_load, o_halted, o_fault,
               o_state_dbg, o_instr_count
    );
endinterface
`default_nettype wire

// File: rtl/scic_step_latch.sv
`default_nettype none
// ============================================================================
// Module      : scic_step_latch
// Description : Rising-edge detector for the single-step switch plus a
//               one-deep pending flag. A new edge while already pending is
//               absorbed. i_consume clears the flag at an instruction
//               boundary; i_clear_all holds it clear (used while halted).
// Ports       : i_clk, i_rst_n (async active-low), i_step, i_consume,
//               i_clear_all, o_pending
// Revision    : 1.0 - initial release
// ============================================================================
module scic_step_latch (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_step,
    input  wire logic i_consume,
    input  wire logic i_clear_all,
    output logic      o_pending
);
    logic r_step_q;
    logic r_pending;
    logic w_rise;

    assign w_rise    = i_step & ~r_step_q;
    assign o_pending = r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_q  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_step_q <= i_step;
            // A fresh edge landing on the consuming boundary is a new request,
            // so setting wins over consuming.
            if (i_clear_all)
                r_pending <= 1'b0;
            else if (w_rise)
                r_pending <= 1'b1;
            else if (i_consume)
                r_pending <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/scic_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : scic_control_unit
// Description : Multi-cycle sequencer for the SCIC accumulator datapath.
//               FETCH -> DECODE -> EXEC [-> WB], with run/single-step gating,
//               sticky halt, illegal-opcode fault and a retired-instruction
//               counter. Control strobes decode from state + IR opcode.
// Ports       : i_clk, i_rst_n (async active-low),
//               bus (scic_ctrl_if.slave): run/step/opcode/acc_zero in;
//               memory, PC, IR, ACC, ALU, LED strobes, halted, fault,
//               state_dbg and instr_count out.
// Revision    : 1.0 - initial release
// ============================================================================
module scic_control_unit #(
    parameter int COUNT_W = 16
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst_n,
    scic_ctrl_if.slave bus
);
    import scic_pkg::*;

    state_t             r_state;
    logic               r_fault;
    logic [COUNT_W-1:0] r_count;

    logic w_pending;
    logic w_go;
    logic w_wb_op;
    logic w_illegal;
    logic w_stop_op;
    logic w_retire;
    logic w_boundary;
    logic w_consume;
    logic w_clear_all;

    assign w_go        = bus.i_run | w_pending;
    assign w_wb_op     = op_needs_wb(bus.i_opcode);
    assign w_illegal   = op_is_illegal(bus.i_opcode);
    assign w_stop_op   = (bus.i_opcode == c_OP_HALT) | w_illegal;
    // Last cycle of an instruction: EXEC of a single-cycle op, or WB.
    assign w_retire    = ((r_state == ST_EXEC) & ~w_wb_op) | (r_state == ST_WB);
    // Places where a pending step may be taken to start the next fetch.
    assign w_boundary  = (r_state == ST_IDLE) | (r_state == ST_WB) |
                         ((r_state == ST_EXEC) & ~w_wb_op & ~w_stop_op);
    assign w_consume   = w_boundary & w_go;
    assign w_clear_all = (r_state == ST_HALT);

    scic_step_latch u_step_latch (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_step      (bus.i_step),
        .i_consume   (w_consume),
        .i_clear_all (w_clear_all),
        .o_pending   (w_pending)
    );

    // Sequencer, fault flag and retired-instruction counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_retire)
                r_count <= r_count + 1'b1;
            case (r_state)
                ST_IDLE:   if (w_go) r_state <= ST_FETCH;
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_wb_op) begin
                        r_state <= ST_WB;
                    end else if (w_stop_op) begin
                        r_state <= ST_HALT;
                        if (w_illegal)
                            r_fault <= 1'b1;
                    end else begin
                        r_state <= w_go ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_WB:     r_state <= w_go ? ST_FETCH : ST_IDLE;
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Control strobe decode.
    always_comb begin
        bus.o_addr_sel = 1'b0;
        bus.o_mem_rd   = 1'b0;
        bus.o_mem_wr   = 1'b0;
        bus.o_ir_load  = 1'b0;
        bus.o_pc_inc   = 1'b0;
        bus.o_pc_load  = 1'b0;
        bus.o_acc_load = 1'b0;
        bus.o_acc_src  = c_SRC_ALU;
        bus.o_alu_op   = c_ALU_ADD;
        bus.o_led_load = 1'b0;
        case (r_state)
            ST_FETCH: begin
                bus.o_mem_rd = 1'b1;
            end
            ST_DECODE: begin
                // Synchronous memory returns the instruction this cycle.
                bus.o_ir_load = 1'b1;
                bus.o_pc_inc  = 1'b1;
            end
            ST_EXEC: begin
                case (bus.i_opcode)
                    c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_AND: begin
                        bus.o_addr_sel = 1'b1;
                        bus.o_mem_rd   = 1'b1;
                    end
                    c_OP_STA: begin
                        bus.o_addr_sel = 1'b1;
                        bus.o_mem_wr   = 1'b1;
                    end
                    c_OP_JMP: bus.o_pc_load = 1'b1;
                    c_OP_JZ:  bus.o_pc_load = bus.i_acc_zero;
                    c_OP_IN: begin
                        bus.o_acc_load = 1'b1;
                        bus.o_acc_src  = c_SRC_SW;
                    end
                    c_OP_OUT: bus.o_led_load = 1'b1;
                    default: ;
                endcase
            end
            ST_WB: begin
                bus.o_acc_load = 1'b1;
                case (bus.i_opcode)
                    c_OP_LDA: bus.o_acc_src = c_SRC_MEM;
                    c_OP_SUB: bus.o_alu_op  = c_ALU_SUB;
                    c_OP_AND: bus.o_alu_op  = c_ALU_AND;
                    default:  bus.o_alu_op  = c_ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.o_halted      = (r_state == ST_HALT);
    assign bus.o_fault       = r_fault;
    assign bus.o_state_dbg   = r_state;
    assign bus.o_instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_scic_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_scic_control_unit
// Description : Directed self-checking bench for scic_control_unit. Uses a
//               4-bit counter so the wrap boundary is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scic_control_unit;
    localparam int c_CW = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    scic_ctrl_if #(.COUNT_W(c_CW)) bus ();

    scic_control_unit #(.COUNT_W(c_CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // {state, addr_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load,
    //  acc_src, alu_op, led_load, halted, fault}
    logic [16:0] w_obs;
    assign w_obs = {bus.o_state_dbg, bus.o_addr_sel, bus.o_mem_rd, bus.o_mem_wr,
                    bus.o_ir_load, bus.o_pc_inc, bus.o_pc_load, bus.o_acc_load,
                    bus.o_acc_src, bus.o_alu_op, bus.o_led_load, bus.o_halted,
                    bus.o_fault};

    function automatic logic [16:0] ev(input logic [2:0] st, input logic [6:0] stb,
                                       input logic [1:0] src, input logic [1:0] alu,
                                       input logic led, input logic h, input logic f);
        return {st, stb, src, alu, led, h, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic run_v, input logic [3:0] op);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_run = run_v;
        bus.i_opcode = op;
        bus.i_step = 1'b0;
        bus.i_acc_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // EXEC-state expectations for single-cycle opcodes
    logic [3:0]  t_op [6];
    logic        t_az [6];
    logic [16:0] t_ex [6];

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.i_run = 1'b0;
        bus.i_step = 1'b0;
        bus.i_opcode = 4'h0;
        bus.i_acc_zero = 1'b0;
        #1;
        chk("rst_out", {15'd0, w_obs}, 32'd0);
        chk("rst_cnt", {28'd0, bus.o_instr_count}, 32'd0);

        // ---- free-running NOPs, counter wrap ----
        do_reset(1'b1, 4'h0);
        chk("nop_idle", {15'd0, w_obs}, {15'd0, ev(3'd0, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        tick; chk("nop_fetch", {15'd0, w_obs}, {15'd0, ev(3'd1, 7'b0100000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        tick; chk("nop_dec", {15'd0, w_obs}, {15'd0, ev(3'd2, 7'b0001100, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        tick; chk("nop_exec", {15'd0, w_obs}, {15'd0, ev(3'd3, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        chk("nop_cnt0", {28'd0, bus.o_instr_count}, 32'd0);
        tick; chk("nop_st4", {29'd0, bus.o_state_dbg}, 32'd1);
        tick; chk("nop_st5", {29'd0, bus.o_state_dbg}, 32'd2);
        tick; chk("nop_st6", {29'd0, bus.o_state_dbg}, 32'd3);
        tick; chk("nop_cnt2", {28'd0, bus.o_instr_count}, 32'd2);
        for (int i = 0; i < 13 * 3; i++) tick;
        chk("nop_cnt15", {28'd0, bus.o_instr_count}, 32'd15);
        for (int i = 0; i < 3; i++) tick;
        chk("nop_wrap", {28'd0, bus.o_instr_count}, 32'd0);

        // ---- ADD then SUB ----
        do_reset(1'b1, 4'h3);
        tick; tick; tick;
        chk("add_exec", {15'd0, w_obs}, {15'd0, ev(3'd3, 7'b1100000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        chk("add_cnt_e", {28'd0, bus.o_instr_count}, 32'd0);
        tick;
        chk("add_wb", {15'd0, w_obs}, {15'd0, ev(3'd4, 7'b0000001, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        chk("add_cnt_w", {28'd0, bus.o_instr_count}, 32'd0);
        tick;
        chk("add_cnt1", {28'd0, bus.o_instr_count}, 32'd1);
        bus.i_opcode = 4'h4;
        tick; tick;
        chk("sub_exec", {15'd0, w_obs}, {15'd0, ev(3'd3, 7'b1100000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        tick;
        chk("sub_wb", {15'd0, w_obs}, {15'd0, ev(3'd4, 7'b0000001, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0)});
        bus.i_opcode = 4'h5;
        tick; tick; tick; tick;
        chk("and_wb", {15'd0, w_obs}, {15'd0, ev(3'd4, 7'b0000001, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0)});

        // ---- single-cycle opcodes in EXEC ----
        t_op[0] = 4'h7; t_az[0] = 1'b1; t_ex[0] = ev(3'd3, 7'b0000010, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        t_op[1] = 4'h7; t_az[1] = 1'b0; t_ex[1] = ev(3'd3, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        t_op[2] = 4'h2; t_az[2] = 1'b0; t_ex[2] = ev(3'd3, 7'b1010000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        t_op[3] = 4'h6; t_az[3] = 1'b0; t_ex[3] = ev(3'd3, 7'b0000010, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        t_op[4] = 4'h8; t_az[4] = 1'b0; t_ex[4] = ev(3'd3, 7'b0000001, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        t_op[5] = 4'h9; t_az[5] = 1'b0; t_ex[5] = ev(3'd3, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1, 4'h0);
        tick;
        for (int i = 0; i < 6; i++) begin
            bus.i_opcode = t_op[i];
            bus.i_acc_zero = t_az[i];
            tick; tick;
            chk($sformatf("exec_op%0h_%0d", t_op[i], i), {15'd0, w_obs}, {15'd0, t_ex[i]});
            tick;
        end
        chk("single_cnt", {28'd0, bus.o_instr_count}, 32'd6);

        // ---- HALT opcode ----
        do_reset(1'b1, 4'hF);
        tick; tick; tick;
        chk("halt_exec", {15'd0, w_obs}, {15'd0, ev(3'd3, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        tick;
        chk("halt_st", {15'd0, w_obs}, {15'd0, ev(3'd5, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0)});
        chk("halt_cnt", {28'd0, bus.o_instr_count}, 32'd1);

        // ---- single step ----
        do_reset(1'b0, 4'h0);
        tick; tick;
        chk("stp_idle", {29'd0, bus.o_state_dbg}, 32'd0);
        bus.i_step = 1'b1;
        tick; chk("stp_pend", {29'd0, bus.o_state_dbg}, 32'd0);
        bus.i_step = 1'b0;
        tick; chk("stp_f1", {29'd0, bus.o_state_dbg}, 32'd1);
        tick; chk("stp_d1", {29'd0, bus.o_state_dbg}, 32'd2);
        bus.i_step = 1'b1;
        tick; chk("stp_e1", {29'd0, bus.o_state_dbg}, 32'd3);
        bus.i_step = 1'b0;
        tick; chk("stp_f2", {29'd0, bus.o_state_dbg}, 32'd1);
        chk("stp_cnt1", {28'd0, bus.o_instr_count}, 32'd1);
        tick; tick; tick;
        chk("stp_idle2", {29'd0, bus.o_state_dbg}, 32'd0);
        tick; tick;
        chk("stp_hold", {29'd0, bus.o_state_dbg}, 32'd0);
        chk("stp_cnt2", {28'd0, bus.o_instr_count}, 32'd2);
        // double pulse inside one ADD: only one extra instruction
        bus.i_opcode = 4'h3;
        bus.i_step = 1'b1;
        tick; bus.i_step = 1'b0;
        tick; chk("dbl_f1", {29'd0, bus.o_state_dbg}, 32'd1);
        bus.i_step = 1'b1;
        tick; bus.i_step = 1'b0;
        tick; bus.i_step = 1'b1;
        tick; chk("dbl_wb", {29'd0, bus.o_state_dbg}, 32'd4);
        bus.i_step = 1'b0;
        tick; chk("dbl_f2", {29'd0, bus.o_state_dbg}, 32'd1);
        tick; tick; tick; tick;
        chk("dbl_idle", {29'd0, bus.o_state_dbg}, 32'd0);
        tick; tick;
        chk("dbl_hold", {29'd0, bus.o_state_dbg}, 32'd0);
        chk("dbl_cnt", {28'd0, bus.o_instr_count}, 32'd4);

        // ---- illegal opcode ----
        do_reset(1'b1, 4'hB);
        tick; tick; tick;
        chk("ill_exec", {15'd0, w_obs}, {15'd0, ev(3'd3, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        tick;
        chk("ill_halt", {15'd0, w_obs}, {15'd0, ev(3'd5, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1)});
        bus.i_run = 1'b0; bus.i_step = 1'b1; bus.i_opcode = 4'h0;
        tick; bus.i_step = 1'b0;
        tick; bus.i_step = 1'b1; bus.i_run = 1'b1;
        tick;
        chk("ill_stuck", {15'd0, w_obs}, {15'd0, ev(3'd5, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1)});
        chk("ill_cnt", {28'd0, bus.o_instr_count}, 32'd1);
        #5 rst_n = 1'b0;
        #1;
        chk("ill_rst", {15'd0, w_obs}, 32'd0);
        chk("ill_rst_cnt", {28'd0, bus.o_instr_count}, 32'd0);

        // ---- reset in the middle of LDA write-back ----
        do_reset(1'b1, 4'h1);
        tick; tick; tick;
        chk("lda_exec", {15'd0, w_obs}, {15'd0, ev(3'd3, 7'b1100000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        tick;
        chk("lda_wb", {15'd0, w_obs}, {15'd0, ev(3'd4, 7'b0000001, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0)});
        #5 rst_n = 1'b0;
        #1;
        chk("lda_rst", {15'd0, w_obs}, 32'd0);
        chk("lda_rst_cnt", {28'd0, bus.o_instr_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("lda_rel", {29'd0, bus.o_state_dbg}, 32'd0);
        tick;
        chk("lda_refetch", {15'd0, w_obs}, {15'd0, ev(3'd1, 7'b0100000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0)});
        chk("lda_re_cnt", {28'd0, bus.o_instr_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
